// File: rtl/seq_shifter_pkg.sv
// Shared types for the sequential B-operand shifter: operation codes and FSM states.
`timescale 1ns/1ps
package seq_shifter_pkg;

   typedef enum logic [1:0] {
      SH_PASS = 2'b00,
      SH_LSL  = 2'b01,
      SH_LSR  = 2'b10,
      SH_ASR  = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   // PASS never shifts, whatever distance is presented with it.
   function automatic logic is_pass(input shift_op_e op);
      return op == SH_PASS;
   endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// One-bit shift step: next work value plus the bit that falls off the end.
`timescale 1ns/1ps
module shift_step
   import seq_shifter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_val,
   input  shift_op_e        i_op,
   output logic [WIDTH-1:0] o_val,
   output logic             o_bit
);

   always_comb begin
      o_val = i_val;
      o_bit = 1'b0;
      case (i_op)
         SH_LSL: begin
            o_val = {i_val[WIDTH-2:0], 1'b0};
            o_bit = i_val[WIDTH-1];
         end
         SH_LSR: begin
            o_val = {1'b0, i_val[WIDTH-1:1]};
            o_bit = i_val[0];
         end
         SH_ASR: begin
            o_val = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
            o_bit = i_val[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter, one bit position per clock, valid/ready on both sides.
// Optional carry output of the last shifted-out bit under SEQ_SHIFTER_CARRY_EN.
`timescale 1ns/1ps
module seq_shifter
   import seq_shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
`ifdef SEQ_SHIFTER_CARRY_EN
   ,
   output logic             carry
`endif
);

   state_e           r_state;
   shift_op_e        r_op;
   logic [WIDTH-1:0] r_work;
   logic [AMT_W-1:0] r_count;
   logic             r_out_valid;
   logic             r_busy;

   shift_op_e        w_op_in;
   logic [AMT_W-1:0] w_amt_eff;
   logic             w_accept;
   logic [WIDTH-1:0] w_step_val;
   logic             w_step_bit;

   assign w_op_in   = shift_op_e'(op);
   assign w_amt_eff = is_pass(w_op_in) ? '0 : amt;
   // DONE hands its slot straight to the next operation when the consumer takes the result.
   assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
   assign w_accept  = in_valid && in_ready;

   assign out_valid = r_out_valid;
   assign out_data  = r_work;
   assign busy      = r_busy;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .i_val (r_work),
      .i_op  (r_op),
      .o_val (w_step_val),
      .o_bit (w_step_bit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op        <= SH_PASS;
         r_work      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_work      <= in_data;
                  r_op        <= w_op_in;
                  r_count     <= w_amt_eff;
                  r_state     <= (w_amt_eff == '0) ? S_DONE : S_SHIFT;
                  r_out_valid <= (w_amt_eff == '0);
                  r_busy      <= 1'b1;
               end else if ((r_state == S_DONE) && out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            S_SHIFT: begin
               r_work  <= w_step_val;
               r_count <= r_count - AMT_W'(1);
               if (r_count == AMT_W'(1)) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEQ_SHIFTER_CARRY_EN
   logic r_carry;
   assign carry = r_carry;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   r_carry <= 1'b0;
      else if (w_accept)           r_carry <= 1'b0;
      else if (r_state == S_SHIFT) r_carry <= w_step_bit;
   end
`else
   logic w_unused_step_bit;
   assign w_unused_step_bit = w_step_bit;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases, then random ops vs. an arithmetic model.
`timescale 1ns/1ps
module tb_seq_shifter;
   import seq_shifter_pkg::*;

   localparam int W     = 16;
   localparam int AW    = 4;
   localparam int N_OPS = 3000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [1:0]    op = '0;
   logic [AW-1:0] amt = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          busy;
   logic          carry;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .op        (op),
      .amt       (amt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef SEQ_SHIFTER_CARRY_EN
      ,
      .carry     (carry)
`endif
   );

`ifndef SEQ_SHIFTER_CARRY_EN
   assign carry = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Model: {carry, result} from plain shift operators.
   function automatic logic [W:0] ref_op(input logic [W-1:0] d, input logic [1:0] o, input int a);
      int ae;
      logic [W-1:0] r;
      logic c;
      ae = (o == 2'b00) ? 0 : a;
      case (o)
         2'b01:   r = d << ae;
         2'b10:   r = d >> ae;
         2'b11:   r = $signed(d) >>> ae;
         default: r = d;
      endcase
      if (ae == 0)        c = 1'b0;
      else if (o == 2'b01) c = d[W-ae];
      else                 c = d[ae-1];
      return {c, r};
   endfunction

   task automatic issue(input logic [W-1:0] d, input logic [1:0] o, input logic [AW-1:0] a);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; op = o; amt = a;
      #1;
      while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
      chk("accept_bound", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = W'($urandom); op = 2'($urandom); amt = AW'($urandom);
   endtask

   task automatic wait_res(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic take();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_dir(input string tag, input logic [W-1:0] d, input logic [1:0] o,
                          input logic [AW-1:0] a, input int elat, input logic [W-1:0] ed,
                          input logic ec);
      int lat;
      issue(d, o, a);
      wait_res(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_data"}, 32'(out_data), 32'(ed));
`ifdef SEQ_SHIFTER_CARRY_EN
      chk({tag, "_carry"}, 32'(carry), 32'(ec));
`else
      if (ec === 1'bx) chk({tag, "_carry_x"}, 32'(ec), 32'd0);
`endif
      take();
      chk({tag, "_idle"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [W:0] q[$];
      logic [W:0] e;
      int         lat, issued, done, guard, exp_cyc;
      bit         waiting;

      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b0; #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_carry", 32'(carry), 32'd0);

      run_dir("lsl4",  16'hF00F, 2'b01, 4'd4,  4,  16'h00F0, 1'b1);
      run_dir("asr1",  16'h8001, 2'b11, 4'd1,  1,  16'hC000, 1'b1);
      run_dir("lsr15", 16'h8001, 2'b10, 4'd15, 15, 16'h0001, 1'b0);
      run_dir("pass7", 16'hA5C3, 2'b00, 4'd7,  0,  16'hA5C3, 1'b0);
      run_dir("lsl0",  16'h5A3C, 2'b01, 4'd0,  0,  16'h5A3C, 1'b0);

      // Reset in the middle of a long shift.
      issue(16'h8001, 2'b10, 4'd15);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1; #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk); reset = 1'b0; #1;
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("mid_rst_stay_idle", 32'(busy), 32'd0);

      // Stall in DONE, then back-to-back handoff.
      issue(16'hF00F, 2'b01, 4'd4);
      wait_res(lat);
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h1234; op = 2'b00; amt = 4'd9;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stall_data", 32'(out_data), 32'h00F0);
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk("stall_valid", 32'(out_valid), 32'd1);
      end
      @(negedge clk); out_ready = 1'b1; #1;
      chk("b2b_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_data", 32'(out_data), 32'h1234);
      chk("b2b_busy", 32'(busy), 32'd1);
      take();
      chk("b2b_idle", 32'(out_valid), 32'd0);

      // Random traffic with consumer stalls.
      issued = 0; done = 0; guard = 0; waiting = 0; exp_cyc = 0;
      while (done < N_OPS && guard < 90000) begin
         @(negedge clk);
         guard++;
         in_valid  = (issued < N_OPS) && ($urandom_range(0, 3) != 0);
         in_data   = W'($urandom);
         op        = 2'($urandom);
         amt       = AW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (waiting && out_valid) begin
            chk("rnd_lat", 32'(cyc), 32'(exp_cyc));
            waiting = 0;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               chk("rnd_data", 32'(out_data), 32'(e[W-1:0]));
`ifdef SEQ_SHIFTER_CARRY_EN
               chk("rnd_carry", 32'(carry), 32'(e[W]));
`endif
            end
            done++;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_op(in_data, op, int'(amt)));
            exp_cyc = cyc + 1 + ((op == 2'b00) ? 0 : int'(amt));
            waiting = 1;
            issued++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("rnd_done", 32'(done), 32'(N_OPS));
      chk("rnd_issued", 32'(issued), 32'(N_OPS));
      chk("rnd_leftover", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
